// File: rtl/slv_mailbox_pkg.sv
// slv_mailbox_pkg
//  Shared definitions for the slave-bus mailbox: register word offsets,
//  STATUS / CTRL bit positions and the TXDATA byte-lane merge helper.
package slv_mailbox_pkg;

    // Register word offsets, decoded from slv_adr_i[3:1].
    typedef enum logic [2:0] {
        ADR_TXDATA = 3'd0,
        ADR_RXDATA = 3'd1,
        ADR_STATUS = 3'd2,
        ADR_COUNT  = 3'd3,
        ADR_CTRL   = 3'd4
    } mbx_reg_e;

    // STATUS bit positions.
    localparam int ST_H2F_EMPTY = 0;
    localparam int ST_H2F_FULL  = 1;
    localparam int ST_F2H_EMPTY = 2;
    localparam int ST_F2H_FULL  = 3;
    localparam int ST_H2F_OVF   = 4;
    localparam int ST_F2H_UDF   = 5;
    localparam int ST_IRQ       = 6;

    // CTRL bit positions (written through the low byte lane).
    localparam int CTRL_FLUSH_H2F = 0;
    localparam int CTRL_FLUSH_F2H = 1;
    localparam int CTRL_CLR_STICKY = 2;
    localparam int CTRL_IRQ_EN    = 3;

    // Disabled byte lanes are stored as zero rather than left unchanged,
    // since each TXDATA write creates a fresh FIFO word.
    function automatic logic [15:0] merge_lanes(input logic [15:0] dat,
                                                input logic [1:0]  sel);
        merge_lanes = {sel[1] ? dat[15:8] : 8'h00,
                       sel[0] ? dat[7:0]  : 8'h00};
    endfunction

endpackage

// File: rtl/slv_mailbox_fifo.sv
// mbx_fifo
//  Synchronous first-word-fall-through FIFO used for both mailbox directions.
//  Ports:
//   clk, srst      clock, synchronous active-high reset
//   push, din      write request and data; accepted if not full, or if a
//                  pop happens in the same cycle (the pop frees the slot)
//   pop            read request; ignored while empty
//   flush          empties the FIFO on the next edge, discarding any
//                  same-cycle push/pop
//   dout           head word (0 while empty)
//   empty, full    flags derived from the registered count
//   count          occupancy 0..2**DEPTH_LOG2
module mbx_fifo #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  do_push;
    logic                  do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_COUNT);
    assign count = count_reg;

    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    // Head is read asynchronously so the word is visible the cycle after
    // it is written; gating with empty keeps dout at 0 after reset/flush
    // even though the storage itself is never cleared.
    assign dout = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/slv_mailbox.sv
// slv_mailbox
//  Register-mapped mailbox on one BAR of the TLP engine slave bus.
//  Host writes to TXDATA feed the host-to-fabric FIFO (drained by a
//  valid/ready stream); fabric words land in the fabric-to-host FIFO,
//  popped by host reads of RXDATA. STATUS, COUNT, CTRL and a level irq.
//  Ports:
//   pcie_clk, sys_rst             clock, synchronous active-high reset
//   slv_bar_i/ce/we/adr/dat/sel   slave bus request
//   slv_dat_o                     registered read data (1-cycle latency)
//   h2f_data/valid/ready          host-to-fabric stream
//   f2h_data/valid/ready          fabric-to-host stream
//   irq                           level interrupt (irq_en & F2H not empty)
module slv_mailbox
    import slv_mailbox_pkg::*;
#(
    parameter int unsigned BAR_IDX    = 1,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic         pcie_clk,
    input  logic         sys_rst,
    input  logic [6:0]   slv_bar_i,
    input  logic         slv_ce_i,
    input  logic         slv_we_i,
    input  logic [19:1]  slv_adr_i,
    input  logic [15:0]  slv_dat_i,
    input  logic [1:0]   slv_sel_i,
    output logic [15:0]  slv_dat_o,
    output logic [15:0]  h2f_data,
    output logic         h2f_valid,
    input  logic         h2f_ready,
    input  logic [15:0]  f2h_data,
    input  logic         f2h_valid,
    output logic         f2h_ready,
    output logic         irq
);

    logic                access;
    logic                wr_access;
    logic                rd_access;
    logic [2:0]          reg_adr;
    logic                tx_push;
    logic                rx_pop;
    logic                ctrl_wr;
    logic                flush_h2f;
    logic                flush_f2h;
    logic                clr_sticky;
    logic                h2f_pop;
    logic                ovf_set;
    logic                udf_set;

    logic                h2f_empty, h2f_full;
    logic                f2h_empty, f2h_full;
    logic [DEPTH_LOG2:0] h2f_count, f2h_count;
    logic [15:0]         f2h_head;

    logic [15:0]         slv_dat_reg, slv_dat_next;
    logic                ovf_reg;
    logic                udf_reg;
    logic                irq_en_reg;
    logic                irq_reg;

    // Only slv_adr_i[3:1] and one BAR bit are decoded.
    logic                unused_bus_bits;
    assign unused_bus_bits = ^{slv_adr_i[19:4], slv_bar_i};

    assign access    = slv_ce_i & slv_bar_i[BAR_IDX];
    assign wr_access = access & slv_we_i;
    assign rd_access = access & ~slv_we_i;
    assign reg_adr   = slv_adr_i[3:1];

    assign tx_push    = wr_access & (reg_adr == ADR_TXDATA) & (|slv_sel_i);
    assign rx_pop     = rd_access & (reg_adr == ADR_RXDATA);
    assign ctrl_wr    = wr_access & (reg_adr == ADR_CTRL) & slv_sel_i[0];
    assign flush_h2f  = ctrl_wr & slv_dat_i[CTRL_FLUSH_H2F];
    assign flush_f2h  = ctrl_wr & slv_dat_i[CTRL_FLUSH_F2H];
    assign clr_sticky = ctrl_wr & slv_dat_i[CTRL_CLR_STICKY];

    assign h2f_valid = ~h2f_empty;
    assign h2f_pop   = h2f_valid & h2f_ready;
    assign f2h_ready = ~f2h_full;

    // A write into a full H2F is only lost when the fabric is not popping
    // in the same cycle; a flush discards the write without flagging it.
    assign ovf_set = tx_push & h2f_full & ~h2f_pop & ~flush_h2f;
    assign udf_set = rx_pop & f2h_empty & ~flush_f2h;

    mbx_fifo #(
        .WIDTH      (16),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_h2f_fifo (
        .clk   (pcie_clk),
        .srst  (sys_rst),
        .push  (tx_push),
        .pop   (h2f_pop),
        .flush (flush_h2f),
        .din   (merge_lanes(slv_dat_i, slv_sel_i)),
        .dout  (h2f_data),
        .empty (h2f_empty),
        .full  (h2f_full),
        .count (h2f_count)
    );

    // The fabric word is offered straight to the FIFO: while full it is
    // still taken if the host pops RXDATA in the same cycle, so a word
    // presented against a stale f2h_ready=0 is not lost in that case.
    mbx_fifo #(
        .WIDTH      (16),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_f2h_fifo (
        .clk   (pcie_clk),
        .srst  (sys_rst),
        .push  (f2h_valid),
        .pop   (rx_pop),
        .flush (flush_f2h),
        .din   (f2h_data),
        .dout  (f2h_head),
        .empty (f2h_empty),
        .full  (f2h_full),
        .count (f2h_count)
    );

    // Read mux; f2h_head is already 0 when F2H is empty.
    always_comb begin
        slv_dat_next = '0;
        case (reg_adr)
            ADR_RXDATA: slv_dat_next = f2h_head;
            ADR_STATUS: begin
                slv_dat_next[ST_H2F_EMPTY] = h2f_empty;
                slv_dat_next[ST_H2F_FULL]  = h2f_full;
                slv_dat_next[ST_F2H_EMPTY] = f2h_empty;
                slv_dat_next[ST_F2H_FULL]  = f2h_full;
                slv_dat_next[ST_H2F_OVF]   = ovf_reg;
                slv_dat_next[ST_F2H_UDF]   = udf_reg;
                slv_dat_next[ST_IRQ]       = irq_reg;
            end
            ADR_COUNT:  slv_dat_next = {8'(f2h_count), 8'(h2f_count)};
            ADR_CTRL:   slv_dat_next = {15'd0, irq_en_reg};
            default:    slv_dat_next = '0;
        endcase
    end

    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            slv_dat_reg <= '0;
            ovf_reg     <= 1'b0;
            udf_reg     <= 1'b0;
            irq_en_reg  <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            if (rd_access) begin
                slv_dat_reg <= slv_dat_next;
            end
            // Set dominates a same-cycle clear.
            ovf_reg <= ovf_set | (ovf_reg & ~clr_sticky);
            udf_reg <= udf_set | (udf_reg & ~clr_sticky);
            if (ctrl_wr) begin
                irq_en_reg <= slv_dat_i[CTRL_IRQ_EN];
            end
            irq_reg <= irq_en_reg & ~f2h_empty;
        end
    end

    assign slv_dat_o = slv_dat_reg;
    assign irq       = irq_reg;

endmodule

// File: tb/tb_slv_mailbox.sv
// tb_slv_mailbox
//  Directed bench for slv_mailbox (BAR_IDX=1, DEPTH_LOG2=4). Expected
//  stream words are queued when stimulus is driven and popped when the DUT
//  delivers them (H2F handshakes, RXDATA reads).
module tb_slv_mailbox;

    logic         clk = 1'b0;
    logic         sys_rst;
    logic [6:0]   slv_bar;
    logic         slv_ce;
    logic         slv_we;
    logic [19:1]  slv_adr;
    logic [15:0]  slv_dat_w;
    logic [1:0]   slv_sel;
    logic [15:0]  slv_dat_o;
    logic [15:0]  h2f_data;
    logic         h2f_valid;
    logic         h2f_ready;
    logic [15:0]  f2h_data;
    logic         f2h_valid;
    logic         f2h_ready;
    logic         irq;

    int checks = 0;
    int errors = 0;

    logic [15:0] h2f_q[$];
    logic [15:0] f2h_q[$];

    localparam logic [6:0] BAR_HIT  = 7'b0000010;
    localparam logic [6:0] BAR_MISS = 7'b0000001;

    slv_mailbox #(
        .BAR_IDX    (1),
        .DEPTH_LOG2 (4)
    ) dut (
        .pcie_clk  (clk),
        .sys_rst   (sys_rst),
        .slv_bar_i (slv_bar),
        .slv_ce_i  (slv_ce),
        .slv_we_i  (slv_we),
        .slv_adr_i (slv_adr),
        .slv_dat_i (slv_dat_w),
        .slv_sel_i (slv_sel),
        .slv_dat_o (slv_dat_o),
        .h2f_data  (h2f_data),
        .h2f_valid (h2f_valid),
        .h2f_ready (h2f_ready),
        .f2h_data  (f2h_data),
        .f2h_valid (f2h_valid),
        .f2h_ready (f2h_ready),
        .irq       (irq)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] adr, input logic [15:0] dat, input logic [1:0] sel);
        slv_ce    = 1'b1;
        slv_we    = 1'b1;
        slv_adr   = 19'(adr);
        slv_dat_w = dat;
        slv_sel   = sel;
        tick();
        slv_ce = 1'b0;
        slv_we = 1'b0;
        $display("write adr=%0d dat=0x%04h sel=%b", adr, dat, sel);
    endtask

    task automatic bus_read(input logic [2:0] adr, output logic [15:0] dat);
        slv_ce  = 1'b1;
        slv_we  = 1'b0;
        slv_adr = 19'(adr);
        tick();
        slv_ce = 1'b0;
        dat    = slv_dat_o;
        $display("read  adr=%0d dat=0x%04h", adr, dat);
    endtask

    task automatic read_chk(input string tag, input logic [2:0] adr, input logic [15:0] exp);
        logic [15:0] d;
        bus_read(adr, d);
        chk(tag, d, exp);
    endtask

    task automatic rx_chk(input string tag);
        logic [15:0] d;
        logic [15:0] exp;
        bus_read(3'd1, d);
        exp = (f2h_q.size() > 0) ? f2h_q.pop_front() : 16'h0000;
        chk(tag, d, exp);
    endtask

    task automatic fabric_push(input logic [15:0] w);
        f2h_valid = 1'b1;
        f2h_data  = w;
        tick();
        f2h_valid = 1'b0;
        f2h_q.push_back(w);
        $display("f2h push 0x%04h", w);
    endtask

    // H2F scoreboard: every handshake must deliver the next queued word.
    always @(negedge clk) begin
        if (!sys_rst && h2f_valid && h2f_ready) begin
            $display("h2f pop 0x%04h", h2f_data);
            if (h2f_q.size() > 0) chk("h2f_stream", h2f_data, h2f_q.pop_front());
            else                  chk("h2f_spurious", {15'd0, h2f_valid}, 16'h0000);
        end
    end

    initial begin
        logic [15:0] d;
        sys_rst   = 1'b1;
        slv_bar   = BAR_HIT;
        slv_ce    = 1'b0;
        slv_we    = 1'b0;
        slv_adr   = '0;
        slv_dat_w = '0;
        slv_sel   = 2'b00;
        h2f_ready = 1'b0;
        f2h_data  = '0;
        f2h_valid = 1'b0;
        repeat (3) tick();
        sys_rst = 1'b0;

        // Reset state
        chk("rst_dat_o", slv_dat_o, 16'h0000);
        chk("rst_h2f_valid", {15'd0, h2f_valid}, 16'h0000);
        chk("rst_f2h_ready", {15'd0, f2h_ready}, 16'h0001);
        chk("rst_h2f_data", h2f_data, 16'h0000);
        chk("rst_irq", {15'd0, irq}, 16'h0000);
        read_chk("rst_status", 3'd2, 16'h0005);
        read_chk("rst_count", 3'd3, 16'h0000);
        read_chk("rst_ctrl", 3'd4, 16'h0000);

        // 1: two words stream straight through
        h2f_ready = 1'b1;
        h2f_q.push_back(16'h1234);
        bus_write(3'd0, 16'h1234, 2'b11);
        h2f_q.push_back(16'hABCD);
        bus_write(3'd0, 16'hABCD, 2'b11);
        repeat (3) tick();
        chk("t1_drained", 16'(h2f_q.size()), 16'h0000);
        read_chk("t1_count", 3'd3, 16'h0000);

        // 2: overflow with fabric stalled, then clear sticky and drain
        h2f_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) h2f_q.push_back(16'h0100 + 16'(i));
            bus_write(3'd0, 16'h0100 + 16'(i), 2'b11);
        end
        read_chk("t2_count_full", 3'd3, 16'h0010);
        read_chk("t2_status_ovf", 3'd2, 16'h0016);
        bus_write(3'd4, 16'h0004, 2'b01);
        read_chk("t2_status_clr", 3'd2, 16'h0006);
        h2f_ready = 1'b1;
        repeat (18) tick();
        chk("t2_drained", 16'(h2f_q.size()), 16'h0000);
        read_chk("t2_count_empty", 3'd3, 16'h0000);
        h2f_ready = 1'b0;

        // 3: fabric to host, then underflow
        fabric_push(16'h00AA);
        fabric_push(16'h0055);
        rx_chk("t3_rx0");
        rx_chk("t3_rx1");
        rx_chk("t3_rx_empty");
        read_chk("t3_status_udf", 3'd2, 16'h0025);
        bus_write(3'd4, 16'h0004, 2'b01);
        read_chk("t3_status_clr", 3'd2, 16'h0005);

        // 4: interrupt timing
        bus_write(3'd4, 16'h0008, 2'b01);
        read_chk("t4_ctrl", 3'd4, 16'h0001);
        fabric_push(16'h0777);
        chk("t4_irq_lag", {15'd0, irq}, 16'h0000);
        tick();
        chk("t4_irq_set", {15'd0, irq}, 16'h0001);
        read_chk("t4_status_irq", 3'd2, 16'h0041);
        rx_chk("t4_rx");
        tick();
        chk("t4_irq_clr", {15'd0, irq}, 16'h0000);
        bus_write(3'd4, 16'h0000, 2'b01);

        // 5: simultaneous push and pop on a full F2H
        for (int i = 0; i < 16; i++) fabric_push(16'h5000 + 16'(i));
        chk("t5_ready_full", {15'd0, f2h_ready}, 16'h0000);
        read_chk("t5_count_full", 3'd3, 16'h1000);
        f2h_valid = 1'b1;
        f2h_data  = 16'h5EEE;
        slv_ce    = 1'b1;
        slv_we    = 1'b0;
        slv_adr   = 19'd1;
        tick();
        slv_ce    = 1'b0;
        f2h_valid = 1'b0;
        $display("read  adr=1 dat=0x%04h with f2h push 0x5eee", slv_dat_o);
        chk("t5_rx_pushpop", slv_dat_o, f2h_q.pop_front());
        f2h_q.push_back(16'h5EEE);
        read_chk("t5_count_kept", 3'd3, 16'h1000);
        for (int i = 0; i < 16; i++) rx_chk("t5_rx_order");
        read_chk("t5_count_empty", 3'd3, 16'h0000);

        // Flush F2H with a same-cycle fabric push (discarded)
        fabric_push(16'h1111);
        fabric_push(16'h2222);
        f2h_valid = 1'b1;
        f2h_data  = 16'h3333;
        bus_write(3'd4, 16'h0002, 2'b01);
        f2h_valid = 1'b0;
        f2h_q.delete();
        chk("flush_f2h_ready", {15'd0, f2h_ready}, 16'h0001);
        read_chk("flush_count", 3'd3, 16'h0000);
        read_chk("flush_status", 3'd2, 16'h0005);

        // 6: byte lanes, unmapped offset, non-BAR access
        bus_write(3'd0, 16'hFFFF, 2'b01);
        chk("t6_lane_lo", h2f_data, 16'h00FF);
        bus_write(3'd0, 16'hFFFF, 2'b00);
        read_chk("t6_sel0_nopush", 3'd3, 16'h0001);
        bus_write(3'd4, 16'h0001, 2'b01);
        chk("t6_flush_h2f", {15'd0, h2f_valid}, 16'h0000);
        bus_write(3'd6, 16'hFFFF, 2'b11);
        read_chk("t6_off6_status", 3'd2, 16'h0005);
        read_chk("t6_off6_count", 3'd3, 16'h0000);
        read_chk("t6_off6_read", 3'd6, 16'h0000);
        read_chk("t6_status_hold", 3'd2, 16'h0005);
        slv_bar = BAR_MISS;
        read_chk("t6_nobar_hold", 3'd3, 16'h0005);
        bus_write(3'd0, 16'h7777, 2'b11);
        chk("t6_nobar_nopush", {15'd0, h2f_valid}, 16'h0000);
        slv_bar = BAR_HIT;

        // Reset mid-transfer
        bus_write(3'd0, 16'h4242, 2'b11);
        fabric_push(16'h4343);
        read_chk("mid_count", 3'd3, 16'h0101);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        f2h_q.delete();
        chk("mid_h2f_valid", {15'd0, h2f_valid}, 16'h0000);
        chk("mid_h2f_data", h2f_data, 16'h0000);
        chk("mid_f2h_ready", {15'd0, f2h_ready}, 16'h0001);
        chk("mid_dat_o", slv_dat_o, 16'h0000);
        read_chk("mid_status", 3'd2, 16'h0005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
